// File: rtl/matrix_ram16_pkg.sv
// Shared constants and types for the ZOOM scaler 2048x16 matrix RAM.
package matrix_ram16_pkg;

  localparam int ADDR_WIDTH = 11;
  localparam int DATA_WIDTH = 16;
  localparam int DEPTH      = 32'd1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/matrix_ram16_outreg.sv
// Reset-clearable read output register; MATRIX_RAM16_RD_OCE_EN adds a load enable rd_oce.
module matrix_ram16_outreg
  import matrix_ram16_pkg::*;
#(
  parameter int DATA_WIDTH = matrix_ram16_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  tb_rst,
`ifdef MATRIX_RAM16_RD_OCE_EN
  input  logic                  rd_oce,
`endif
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic                  load_s;
  logic [DATA_WIDTH-1:0] q_r;

`ifdef MATRIX_RAM16_RD_OCE_EN
  assign load_s = rd_oce;
`else
  assign load_s = 1'b1;
`endif

  // Output stage: cleared asynchronously, otherwise loads d when enabled.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      q_r <= '0;
    end else if (load_s) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/matrix_ram16_sp.sv
// Single-port 2048x16 read-before-write block RAM with 1- or 2-cycle read latency.
// Optional output-register load enable via `define MATRIX_RAM16_RD_OCE_EN.
module matrix_ram16_sp
  import matrix_ram16_pkg::*;
#(
  parameter int ADDR_WIDTH = matrix_ram16_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = matrix_ram16_pkg::DATA_WIDTH,
  parameter int OUTPUT_REG = 1
) (
  input  logic                  clk,
  input  logic                  tb_rst,
`ifdef MATRIX_RAM16_RD_OCE_EN
  input  logic                  rd_oce,
`endif
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int MEM_DEPTH = 32'd1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] q1_r;

  // Array write port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

  // Stage-1 read register; NBA ordering yields the pre-write contents.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      q1_r <= '0;
    end else begin
      q1_r <= mem[addr];
    end
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    matrix_ram16_outreg #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_outreg (
      .clk    (clk),
      .tb_rst (tb_rst),
`ifdef MATRIX_RAM16_RD_OCE_EN
      .rd_oce (rd_oce),
`endif
      .d      (q1_r),
      .q      (rd_data)
    );
  end else begin : g_noreg
    assign rd_data = q1_r;
  end

endmodule

// File: tb/tb_matrix_ram16_sp.sv
// Directed self-checking bench for matrix_ram16_sp (default OUTPUT_REG=1, latency 2).
module tb_matrix_ram16_sp;

  logic        clk;
  logic        tb_rst;
  logic [10:0] addr;
  logic [15:0] wr_data;
  logic        wr_en;
  logic [15:0] rd_data;
`ifdef MATRIX_RAM16_RD_OCE_EN
  logic        rd_oce;
`endif

  int checks;
  int errors;

  matrix_ram16_sp dut (
    .clk     (clk),
    .tb_rst  (tb_rst),
`ifdef MATRIX_RAM16_RD_OCE_EN
    .rd_oce  (rd_oce),
`endif
    .addr    (addr),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full pass writes addr (i+1)%2048 with 16'hFFFF-i, so address a holds FFFF - ((a+2047)%2048).
  function automatic logic [15:0] val_at(input int a);
    int idx;
    idx = (a + 2047) % 2048;
    return 16'hFFFF - 16'(idx);
  endfunction

  initial begin
    checks  = 0;
    errors  = 0;
    tb_rst  = 1'b0;
    wr_en   = 1'b0;
    addr    = 11'd0;
    wr_data = 16'h0000;
`ifdef MATRIX_RAM16_RD_OCE_EN
    rd_oce  = 1'b1;
`endif

    // Reset asserted mid-cycle must clear rd_data at once, then hold for 200 ns.
    #7 tb_rst = 1'b1;
    #1 check_eq("rst_immediate", rd_data, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq($sformatf("rst_hold_%0d", i), rd_data, 16'h0000);
    end

    // Write pass: addr 1..2047 then 0, data FFFF decrementing.
    @(negedge clk);
    tb_rst = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      if (i > 0) @(negedge clk);
      addr    = 11'((i + 1) % 2048);
      wr_data = 16'hFFFF - 16'(i);
      wr_en   = 1'b1;
    end

    // Read pass: same sequence, result two cycles after each address.
    for (int i = 0; i < 2050; i++) begin
      @(negedge clk);
      if (i >= 2) check_eq($sformatf("full_rd_%0d", i - 2), rd_data, 16'hFFFF - 16'(i - 2));
      if (i < 2048) begin
        addr  = 11'((i + 1) % 2048);
        wr_en = 1'b0;
      end
    end

    // Read-before-write on address 5.
    @(negedge clk);
    addr = 11'd5; wr_en = 1'b1; wr_data = 16'h1234;
    @(negedge clk);
    addr = 11'd5; wr_en = 1'b1; wr_data = 16'hABCD;
    @(negedge clk);
    check_eq("rbw_first_old", rd_data, val_at(5));
    addr = 11'd5; wr_en = 1'b0;
    @(negedge clk);
    check_eq("rbw_old_1234", rd_data, 16'h1234);
    @(negedge clk);
    check_eq("rbw_new_abcd", rd_data, 16'hABCD);

    // Latency: alternate 10/20 holding 000A/0014.
    addr = 11'd10; wr_en = 1'b1; wr_data = 16'h000A;
    @(negedge clk);
    addr = 11'd20; wr_en = 1'b1; wr_data = 16'h0014;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) check_eq($sformatf("latency_%0d", i), rd_data, (i % 2 == 0) ? 16'h000A : 16'h0014);
      wr_en = 1'b0;
      addr  = (i % 2 == 0) ? 11'd10 : 11'd20;
    end

    // Mid-operation reset during streaming reads.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i >= 2) check_eq($sformatf("pre_rst_%0d", i), rd_data, val_at(400 + i - 2));
      addr = 11'(400 + i);
    end
    @(posedge clk);
    #2 tb_rst = 1'b1;
    #1 check_eq("midrst_immediate", rd_data, 16'h0000);
    @(negedge clk);
    check_eq("midrst_hold", rd_data, 16'h0000);
    tb_rst = 1'b0;
    addr   = 11'd200;
    @(negedge clk);
    check_eq("post_rst_first_edge", rd_data, 16'h0000);
    addr = 11'd201;
    @(negedge clk);
    check_eq("post_rst_200", rd_data, val_at(200));
    addr = 11'd202;
    @(negedge clk);
    check_eq("post_rst_201", rd_data, val_at(201));

`ifdef MATRIX_RAM16_RD_OCE_EN
    // rd_oce low for edges 5..7 freezes rd_data at the value from addr 303.
    begin
      int exp_addr [9];
      exp_addr = '{300, 301, 302, 303, 303, 303, 303, 307, 308};
      for (int k = 0; k < 11; k++) begin
        @(negedge clk);
        if (k >= 2) check_eq($sformatf("oce_%0d", k), rd_data, val_at(exp_addr[k - 2]));
        addr   = 11'(300 + k);
        rd_oce = (k >= 5 && k <= 7) ? 1'b0 : 1'b1;
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
